getir1: RTL

- First fetch stage: owns the fetch program counter (PS) and issues word-aligned instruction requests to the L1 instruction cache (L1B).
- Records the full PS of every live request in a small in-order PS queue and presents the oldest entry to getir2, which pairs it with the returning L1B word.
- Applies redirects from execute (mispredict) and from getir2's branch predictor, and supports pipeline stall.

---
 rtl/getir1_pkg.sv | 19 +
 rtl/getir1_ps_kuyrugu.sv | 56 +++++
 rtl/getir1.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/getir1_pkg.sv
// Shared constants, state encoding and address helper for the first fetch stage.
package getir1_pkg;

    localparam int PS_BIT = 32;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    typedef enum logic {
        G1_BOSTA = 1'b0,
        G1_ISTEK = 1'b1
    } g1_durum_e;

    // Instruction cache requests are always word aligned.
    function automatic logic [PS_BIT-1:0] hizala(input logic [PS_BIT-1:0] ps);
        return {ps[PS_BIT-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/getir1_ps_kuyrugu.sv
// In-order PS queue: synchronous FIFO with flush, holding the PS of every live request.
module getir1_ps_kuyrugu #(
    parameter int DERINLIK = 4,
    parameter int GENISLIK = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [GENISLIK-1:0]          veri_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [GENISLIK-1:0]          veri_o,
    output logic [$clog2(DERINLIK):0]    sayac_o,
    output logic                         bos_o
);

    localparam int PW = $clog2(DERINLIK);

    logic [GENISLIK-1:0] mem_q [DERINLIK];
    logic [PW-1:0]       yaz_q;
    logic [PW-1:0]       oku_q;
    logic [PW:0]         sayac_q;
    logic                dolu;
    logic                yaz_izin;
    logic                oku_izin;

    assign dolu     = (sayac_q == (PW+1)'(DERINLIK));
    assign yaz_izin = push_i && !dolu;
    assign oku_izin = pop_i && (sayac_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yaz_q   <= '0;
            oku_q   <= '0;
            sayac_q <= '0;
        end else if (flush_i) begin
            yaz_q   <= '0;
            oku_q   <= '0;
            sayac_q <= '0;
        end else begin
            if (yaz_izin) yaz_q <= yaz_q + 1'b1;
            if (oku_izin) oku_q <= oku_q + 1'b1;
            sayac_q <= sayac_q + (PW+1)'(yaz_izin) - (PW+1)'(oku_izin);
        end
    end

    // Storage needs no reset; the head is masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (yaz_izin && !flush_i) mem_q[yaz_q] <= veri_i;
    end

    assign bos_o   = (sayac_q == '0);
    assign sayac_o = sayac_q;
    assign veri_o  = bos_o ? '0 : mem_q[oku_q];

endmodule

// File: rtl/getir1.sv
// First fetch stage: owns the fetch PS, issues aligned L1B requests, tracks live requests for getir2.
module getir1
    import getir1_pkg::*;
#(
    parameter logic [PS_BIT-1:0] BASLANGIC_PS = 32'h4000_0000,
    parameter int                PS_DERINLIK  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [PS_BIT-1:0] l1b_istek_adres_o,
    output logic              l1b_istek_gecerli_o,
    input  logic              l1b_istek_hazir_i,
    output logic              g1_istek_yapildi_o,
    output logic [PS_BIT-1:0] g2_ps_o,
    output logic              g2_ps_gecerli_o,
    input  logic              g2_ps_hazir_i,
    input  logic [PS_BIT-1:0] g2_dallanma_ps_i,
    input  logic              g2_dallanma_gecerli_i,
    input  logic [PS_BIT-1:0] yurut_ps_i,
    input  logic              yurut_ps_gecerli_i,
    input  logic              cek_duraklat_i,
    output g1_durum_e         durum_o
);

    // Request channel: l1b_istek_gecerli_o stays high with a stable address until the
    // cycle l1b_istek_hazir_i is seen high; that cycle is the handshake.

    localparam int SW = $clog2(PS_DERINLIK) + 1;

    g1_durum_e         durum_q, durum_d;
    logic [PS_BIT-1:0] ps_q, ps_d;
    logic [PS_BIT-1:0] adres_q, adres_d;
    logic [PS_BIT-1:0] istek_ps_q, istek_ps_d;
    logic              bayat_q, bayat_d;

    logic              el_sikisma;
    logic              yonlendir;
    logic [PS_BIT-1:0] hedef;
    logic              push;
    logic              pop;
    logic [SW-1:0]     sayac;
    logic [SW-1:0]     sayac_sonra;
    logic              ihrac_uygun;
    logic              kuyruk_bos;
    logic [PS_BIT-1:0] kuyruk_bas;
    logic [PS_BIT-1:0] ps_sirali;

    assign el_sikisma  = (durum_q == G1_ISTEK) && l1b_istek_hazir_i;
    assign yonlendir   = yurut_ps_gecerli_i || g2_dallanma_gecerli_i;
    assign hedef       = yurut_ps_gecerli_i ? yurut_ps_i : g2_dallanma_ps_i;
    assign push        = el_sikisma && !bayat_q && !yonlendir;
    assign pop         = !kuyruk_bos && g2_ps_hazir_i && !cek_duraklat_i && !yonlendir;
    assign sayac_sonra = sayac + SW'(push) - SW'(pop);
    // Post-push occupancy keeps queued plus pending live requests within the depth.
    assign ihrac_uygun = !cek_duraklat_i && (sayac_sonra < SW'(PS_DERINLIK));
    assign ps_sirali   = hizala(ps_q) + PS_BIT'(4);

    getir1_ps_kuyrugu #(
        .DERINLIK (PS_DERINLIK),
        .GENISLIK (PS_BIT)
    ) u_kuyruk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .veri_i  (istek_ps_q),
        .pop_i   (pop),
        .flush_i (yonlendir),
        .veri_o  (kuyruk_bas),
        .sayac_o (sayac),
        .bos_o   (kuyruk_bos)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q    <= G1_BOSTA;
            ps_q       <= BASLANGIC_PS;
            adres_q    <= '0;
            istek_ps_q <= '0;
            bayat_q    <= LOW;
        end else begin
            durum_q    <= durum_d;
            ps_q       <= ps_d;
            adres_q    <= adres_d;
            istek_ps_q <= istek_ps_d;
            bayat_q    <= bayat_d;
        end
    end

    always_comb begin
        durum_d    = durum_q;
        ps_d       = ps_q;
        adres_d    = adres_q;
        istek_ps_d = istek_ps_q;
        bayat_d    = bayat_q;
        if (yonlendir) begin
            ps_d = hedef;
            // An unaccepted request must still finish its handshake, but it is now stale.
            if ((durum_q == G1_ISTEK) && !el_sikisma) begin
                bayat_d = HIGH;
            end else begin
                bayat_d = LOW;
                durum_d = G1_BOSTA;
            end
        end else begin
            case (durum_q)
                G1_BOSTA: begin
                    if (ihrac_uygun) begin
                        durum_d    = G1_ISTEK;
                        adres_d    = hizala(ps_q);
                        istek_ps_d = ps_q;
                    end
                end
                G1_ISTEK: begin
                    if (el_sikisma) begin
                        if (bayat_q) begin
                            bayat_d = LOW;
                            durum_d = G1_BOSTA;
                        end else begin
                            ps_d = ps_sirali;
                            if (ihrac_uygun) begin
                                adres_d    = hizala(ps_sirali);
                                istek_ps_d = ps_sirali;
                            end else begin
                                durum_d = G1_BOSTA;
                            end
                        end
                    end
                end
                default: durum_d = G1_BOSTA;
            endcase
        end
    end

    always_comb begin
        l1b_istek_adres_o   = adres_q;
        l1b_istek_gecerli_o = (durum_q == G1_ISTEK);
        g1_istek_yapildi_o  = el_sikisma;
        g2_ps_o             = kuyruk_bas;
        g2_ps_gecerli_o     = !kuyruk_bos;
        durum_o             = durum_q;
    end

endmodule
